rv32_fetch_bp: RTL and testbench

Parametrised instruction-fetch stage with a dynamic branch predictor. It generates the PC, issues the instruction read, and predicts JAL and conditional-branch targets. Predictions come from a bimodal table of 2-bit saturating counters, or from the static backward-taken rule. A memory-ready handshake tolerates wait states. The block sits at the head of the rv32 pipeline, feeding decode, with redirect and predictor-update inputs from the mem stage.

---
 rtl/rv32_fetch_bp_if.sv | 23 ++
 rtl/rv32_fetch_bp.sv | 185 ++++++++++++++++++
 tb/tb_rv32_fetch_bp.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_fetch_bp_if.sv
// Instruction bus between the fetch stage and instruction memory.
// The fetch stage is the master: it presents the address and read strobe,
// and memory answers with the instruction word and a ready flag.
interface rv32_fetch_bp_if;
   logic        instr_read_out;
   logic [31:0] instr_address_out;
   logic [31:0] instr_read_value_in;
   logic        instr_read_ready_in;

   modport master (
      output instr_read_out,
      output instr_address_out,
      input  instr_read_value_in,
      input  instr_read_ready_in
   );

   modport slave (
      input  instr_read_out,
      input  instr_address_out,
      output instr_read_value_in,
      output instr_read_ready_in
   );
endinterface

// File: rtl/rv32_fetch_bp.sv
// RV32 instruction-fetch stage with a branch predictor.
// It generates the PC and fetches from the instruction bus. JAL targets are
// predicted taken. Conditional-branch targets are predicted either by a
// bimodal table of 2-bit counters or by the static backward-taken rule.
// A mispredict redirect that arrives while the PC is stalled is held in a
// latch. The latched redirect is applied on the first cycle the stall drops.
module rv32_fetch_bp #(
   parameter int          BHT_ENTRIES    = 64,
   parameter int          PREDICTOR_MODE = 1,
   parameter logic [31:0] RESET_PC       = 32'h0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 pcgen_stall_in,
   input  logic                 stall_in,
   input  logic                 flush_in,
   input  logic                 branch_mispredicted_in,
   input  logic [31:0]          branch_pc_in,
   input  logic                 update_valid_in,
   input  logic [31:0]          update_pc_in,
   input  logic                 update_taken_in,
   rv32_fetch_bp_if.master      bus,
   output logic                 valid_out,
   output logic                 branch_predicted_taken_out,
   output logic [31:0]          pc_out,
   output logic [31:0]          instr_out
);

   localparam int          IDX_W      = $clog2(BHT_ENTRIES);
   localparam logic [31:0] NOP        = 32'h0000_0013;
   localparam logic [6:0]  OP_JAL     = 7'b1101111;
   localparam logic [6:0]  OP_BRANCH  = 7'b1100011;

   logic [31:0]      pc_q, pc_d;
   logic             latch_valid_q, latch_valid_d;
   logic [31:0]      latch_pc_q, latch_pc_d;
   logic [1:0]       bht_q [BHT_ENTRIES];
   logic [1:0]       bht_d [BHT_ENTRIES];
   logic             valid_q, valid_d;
   logic             taken_q, taken_d;
   logic [31:0]      pc_out_q, pc_out_d;
   logic [31:0]      instr_q, instr_d;

   logic [31:0]      instr;
   logic [6:0]       opcode;
   logic [31:0]      imm_j;
   logic [31:0]      imm_b;
   logic [IDX_W-1:0] fetch_idx;
   logic [IDX_W-1:0] update_idx;
   logic             pred_taken;
   logic [31:0]      offset;
   logic [31:0]      next_pc;
   logic             unused_update_pc;

   assign instr      = bus.instr_read_value_in;
   assign opcode     = instr[6:0];
   assign imm_j      = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   assign imm_b      = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign fetch_idx  = pc_q[IDX_W+1:2];
   assign update_idx = update_pc_in[IDX_W+1:2];

   assign unused_update_pc = ^{update_pc_in[31:IDX_W+2], update_pc_in[1:0]};

   assign bus.instr_read_out    = 1'b1;
   assign bus.instr_address_out = pc_q;

   assign valid_out                  = valid_q;
   assign branch_predicted_taken_out = taken_q;
   assign pc_out                     = pc_out_q;
   assign instr_out                  = instr_q;

   // Predict the direction and PC offset of the word returned this cycle;
   // the table is read before any same-cycle update lands
   always_comb begin
      pred_taken = 1'b0;
      offset     = 32'd4;
      if (bus.instr_read_ready_in) begin
         if (opcode == OP_JAL) begin
            pred_taken = 1'b1;
            offset     = imm_j;
         end else if (opcode == OP_BRANCH) begin
            if (PREDICTOR_MODE == 0) begin
               pred_taken = instr[31];
            end else begin
               pred_taken = bht_q[fetch_idx][1];
            end
            if (pred_taken) begin
               offset = imm_b;
            end
         end
      end
   end

   // Choose the next PC: latched redirect, live redirect, refetch on wait, then sequential/predicted
   always_comb begin
      if (latch_valid_q) begin
         next_pc = latch_pc_q;
      end else if (branch_mispredicted_in) begin
         next_pc = branch_pc_in;
      end else if (!bus.instr_read_ready_in) begin
         next_pc = pc_q;
      end else begin
         next_pc = pc_q + offset;
      end
   end

   // Advance the PC unless stalled; while stalled, remember the first redirect only
   always_comb begin
      pc_d          = pc_q;
      latch_valid_d = latch_valid_q;
      latch_pc_d    = latch_pc_q;
      if (pcgen_stall_in) begin
         if (!latch_valid_q && branch_mispredicted_in) begin
            latch_valid_d = 1'b1;
            latch_pc_d    = branch_pc_in;
         end
      end else begin
         pc_d          = next_pc;
         latch_valid_d = 1'b0;
      end
   end

   // Train the counter of the resolved branch, saturating at both ends
   always_comb begin
      bht_d = bht_q;
      if (update_valid_in) begin
         if (update_taken_in) begin
            if (bht_q[update_idx] != 2'b11) begin
               bht_d[update_idx] = bht_q[update_idx] + 2'b01;
            end
         end else begin
            if (bht_q[update_idx] != 2'b00) begin
               bht_d[update_idx] = bht_q[update_idx] - 2'b01;
            end
         end
      end
   end

   // Load the decode-facing register, substituting a bubble when the fetch is not usable
   always_comb begin
      valid_d  = valid_q;
      taken_d  = taken_q;
      pc_out_d = pc_out_q;
      instr_d  = instr_q;
      if (!stall_in) begin
         if (flush_in || latch_valid_q || !bus.instr_read_ready_in) begin
            valid_d  = 1'b0;
            taken_d  = 1'b0;
            pc_out_d = 32'h0;
            instr_d  = NOP;
         end else begin
            valid_d  = 1'b1;
            taken_d  = pred_taken;
            pc_out_d = pc_q;
            instr_d  = instr;
         end
      end
   end

   // State registers; reset wins over everything, including a pending table update
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q          <= RESET_PC;
         latch_valid_q <= 1'b0;
         latch_pc_q    <= 32'h0;
         valid_q       <= 1'b0;
         taken_q       <= 1'b0;
         pc_out_q      <= 32'h0;
         instr_q       <= NOP;
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht_q[i] <= 2'b01;
         end
      end else begin
         pc_q          <= pc_d;
         latch_valid_q <= latch_valid_d;
         latch_pc_q    <= latch_pc_d;
         valid_q       <= valid_d;
         taken_q       <= taken_d;
         pc_out_q      <= pc_out_d;
         instr_q       <= instr_d;
         bht_q         <= bht_d;
      end
   end

endmodule

// File: tb/tb_rv32_fetch_bp.sv
// Directed testbench for rv32_fetch_bp.
// Two instances share stimulus: one uses the bimodal predictor, and one uses
// the static predictor with a non-zero reset PC.
module tb_rv32_fetch_bp;

   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] BEQ_M16 = 32'hFE00_08E3;
   localparam logic [31:0] BNE_P8  = 32'h0000_1463;
   localparam logic [31:0] JAL_80  = 32'h0800_006F;

   logic        clk;
   logic        reset;
   logic        pcgen_stall, stall, flush, mispredict;
   logic [31:0] branch_pc;
   logic        upd_valid, upd_taken;
   logic [31:0] upd_pc;
   logic [31:0] rd_value;
   logic        rd_ready;

   logic        valid_b, taken_b, valid_s, taken_s;
   logic [31:0] pcout_b, instr_b, pcout_s, instr_s;

   int n_cmp;
   int n_fail;

   rv32_fetch_bp_if bus_b ();
   rv32_fetch_bp_if bus_s ();

   assign bus_b.instr_read_value_in = rd_value;
   assign bus_b.instr_read_ready_in = rd_ready;
   assign bus_s.instr_read_value_in = rd_value;
   assign bus_s.instr_read_ready_in = rd_ready;

   rv32_fetch_bp #(.BHT_ENTRIES(64), .PREDICTOR_MODE(1), .RESET_PC(32'h0)) dut_b (
      .clk(clk), .reset(reset), .pcgen_stall_in(pcgen_stall), .stall_in(stall),
      .flush_in(flush), .branch_mispredicted_in(mispredict), .branch_pc_in(branch_pc),
      .update_valid_in(upd_valid), .update_pc_in(upd_pc), .update_taken_in(upd_taken),
      .bus(bus_b), .valid_out(valid_b), .branch_predicted_taken_out(taken_b),
      .pc_out(pcout_b), .instr_out(instr_b)
   );

   rv32_fetch_bp #(.BHT_ENTRIES(16), .PREDICTOR_MODE(0), .RESET_PC(32'h100)) dut_s (
      .clk(clk), .reset(reset), .pcgen_stall_in(pcgen_stall), .stall_in(stall),
      .flush_in(flush), .branch_mispredicted_in(mispredict), .branch_pc_in(branch_pc),
      .update_valid_in(upd_valid), .update_pc_in(upd_pc), .update_taken_in(upd_taken),
      .bus(bus_s), .valid_out(valid_s), .branch_predicted_taken_out(taken_s),
      .pc_out(pcout_s), .instr_out(instr_s)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic redirect(input logic [31:0] target);
      mispredict = 1'b1;
      branch_pc  = target;
      rd_value   = NOP;
      step();
      mispredict = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      n_cmp++; if (valid_b !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_valid: got %b expected 0", valid_b); end
      n_cmp++; if (taken_b !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_taken: got %b expected 0", taken_b); end
      n_cmp++; if (pcout_b !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_pc_out: got %h expected 0", pcout_b); end
      n_cmp++; if (instr_b !== NOP) begin n_fail++; $display("[TB] FAIL rst_instr: got %h expected %h", instr_b, NOP); end
      n_cmp++; if (bus_b.instr_read_out !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_read: got %b expected 1", bus_b.instr_read_out); end
      n_cmp++; if (bus_b.instr_address_out !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_addr: got %h expected 0", bus_b.instr_address_out); end
      n_cmp++; if (bus_s.instr_address_out !== 32'h100) begin n_fail++; $display("[TB] FAIL rst_addr_s: got %h expected 100", bus_s.instr_address_out); end
      reset = 1'b0;
   endtask

   task automatic test_sequential();
      rd_value = NOP;
      step();
      n_cmp++; if (bus_b.instr_address_out !== 32'h4) begin n_fail++; $display("[TB] FAIL seq_addr4: got %h expected 4", bus_b.instr_address_out); end
      n_cmp++; if (valid_b !== 1'b1) begin n_fail++; $display("[TB] FAIL seq_valid: got %b expected 1", valid_b); end
      n_cmp++; if (pcout_b !== 32'h0) begin n_fail++; $display("[TB] FAIL seq_pc0: got %h expected 0", pcout_b); end
      step();
      n_cmp++; if (bus_b.instr_address_out !== 32'h8) begin n_fail++; $display("[TB] FAIL seq_addr8: got %h expected 8", bus_b.instr_address_out); end
      n_cmp++; if (pcout_b !== 32'h4) begin n_fail++; $display("[TB] FAIL seq_pc4: got %h expected 4", pcout_b); end
      step();
      n_cmp++; if (bus_b.instr_address_out !== 32'hC) begin n_fail++; $display("[TB] FAIL seq_addrC: got %h expected C", bus_b.instr_address_out); end
      n_cmp++; if (pcout_b !== 32'h8) begin n_fail++; $display("[TB] FAIL seq_pc8: got %h expected 8", pcout_b); end
   endtask

   task automatic test_bht_training();
      redirect(32'h40);
      n_cmp++; if (bus_b.instr_address_out !== 32'h40) begin n_fail++; $display("[TB] FAIL bht_redir: got %h expected 40", bus_b.instr_address_out); end
      rd_value = BEQ_M16;
      step();
      n_cmp++; if (bus_b.instr_address_out !== 32'h44) begin n_fail++; $display("[TB] FAIL bht_first_addr: got %h expected 44", bus_b.instr_address_out); end
      n_cmp++; if (taken_b !== 1'b0) begin n_fail++; $display("[TB] FAIL bht_first_taken: got %b expected 0", taken_b); end
      n_cmp++; if (instr_b !== BEQ_M16) begin n_fail++; $display("[TB] FAIL bht_first_instr: got %h expected %h", instr_b, BEQ_M16); end
      rd_value  = NOP;
      upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1;
      step(); step();
      upd_valid = 1'b0;
      redirect(32'h40);
      rd_value = BEQ_M16;
      step();
      n_cmp++; if (bus_b.instr_address_out !== 32'h30) begin n_fail++; $display("[TB] FAIL bht_trained_addr: got %h expected 30", bus_b.instr_address_out); end
      n_cmp++; if (taken_b !== 1'b1) begin n_fail++; $display("[TB] FAIL bht_trained_taken: got %b expected 1", taken_b); end
      n_cmp++; if (pcout_b !== 32'h40) begin n_fail++; $display("[TB] FAIL bht_trained_pc: got %h expected 40", pcout_b); end
      rd_value  = NOP;
      upd_valid = 1'b1; upd_taken = 1'b0;
      step(); step(); step(); step();
      upd_valid = 1'b0;
      n_cmp++; if (bus_b.instr_address_out !== 32'h40) begin n_fail++; $display("[TB] FAIL bht_wrap_to_40: got %h expected 40", bus_b.instr_address_out); end
      rd_value = BEQ_M16;
      step();
      n_cmp++; if (bus_b.instr_address_out !== 32'h44) begin n_fail++; $display("[TB] FAIL bht_untrained_addr: got %h expected 44", bus_b.instr_address_out); end
      n_cmp++; if (taken_b !== 1'b0) begin n_fail++; $display("[TB] FAIL bht_untrained_taken: got %b expected 0", taken_b); end
   endtask

   task automatic test_collision();
      rd_value  = NOP;
      upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1;
      step();
      upd_valid = 1'b0;
      redirect(32'h40);
      rd_value  = BEQ_M16;
      upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1;
      step();
      upd_valid = 1'b0;
      n_cmp++; if (bus_b.instr_address_out !== 32'h44) begin n_fail++; $display("[TB] FAIL coll_old_addr: got %h expected 44", bus_b.instr_address_out); end
      n_cmp++; if (taken_b !== 1'b0) begin n_fail++; $display("[TB] FAIL coll_old_taken: got %b expected 0", taken_b); end
      redirect(32'h40);
      rd_value = BEQ_M16;
      step();
      n_cmp++; if (bus_b.instr_address_out !== 32'h30) begin n_fail++; $display("[TB] FAIL coll_new_addr: got %h expected 30", bus_b.instr_address_out); end
      n_cmp++; if (taken_b !== 1'b1) begin n_fail++; $display("[TB] FAIL coll_new_taken: got %b expected 1", taken_b); end
   endtask

   task automatic test_static();
      rd_value  = NOP;
      upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b0;
      step(); step();
      upd_valid = 1'b0;
      redirect(32'h40);
      rd_value = BEQ_M16;
      step();
      n_cmp++; if (bus_s.instr_address_out !== 32'h30) begin n_fail++; $display("[TB] FAIL static_bwd_addr: got %h expected 30", bus_s.instr_address_out); end
      n_cmp++; if (taken_s !== 1'b1) begin n_fail++; $display("[TB] FAIL static_bwd_taken: got %b expected 1", taken_s); end
      n_cmp++; if (bus_b.instr_address_out !== 32'h44) begin n_fail++; $display("[TB] FAIL bimodal_contrast_addr: got %h expected 44", bus_b.instr_address_out); end
      redirect(32'h40);
      rd_value = BNE_P8;
      step();
      n_cmp++; if (bus_s.instr_address_out !== 32'h44) begin n_fail++; $display("[TB] FAIL static_fwd_addr: got %h expected 44", bus_s.instr_address_out); end
      n_cmp++; if (taken_s !== 1'b0) begin n_fail++; $display("[TB] FAIL static_fwd_taken: got %b expected 0", taken_s); end
   endtask

   task automatic test_redirect_stall();
      redirect(32'h60);
      pcgen_stall = 1'b1;
      mispredict  = 1'b1; branch_pc = 32'h100;
      step();
      n_cmp++; if (bus_b.instr_address_out !== 32'h60) begin n_fail++; $display("[TB] FAIL rs_hold1: got %h expected 60", bus_b.instr_address_out); end
      n_cmp++; if (valid_b !== 1'b1 || pcout_b !== 32'h60) begin n_fail++; $display("[TB] FAIL rs_out1: got valid %b pc %h expected 1 60", valid_b, pcout_b); end
      branch_pc = 32'h200;
      step();
      n_cmp++; if (bus_b.instr_address_out !== 32'h60) begin n_fail++; $display("[TB] FAIL rs_hold2: got %h expected 60", bus_b.instr_address_out); end
      n_cmp++; if (valid_b !== 1'b0) begin n_fail++; $display("[TB] FAIL rs_bubble2: got %b expected 0", valid_b); end
      mispredict = 1'b0;
      step();
      pcgen_stall = 1'b0;
      step();
      n_cmp++; if (bus_b.instr_address_out !== 32'h100) begin n_fail++; $display("[TB] FAIL rs_target: got %h expected 100", bus_b.instr_address_out); end
      n_cmp++; if (valid_b !== 1'b0 || instr_b !== NOP || pcout_b !== 32'h0) begin n_fail++; $display("[TB] FAIL rs_release_bubble: got valid %b instr %h pc %h expected 0 %h 0", valid_b, instr_b, pcout_b, NOP); end
      step();
      n_cmp++; if (bus_b.instr_address_out !== 32'h104) begin n_fail++; $display("[TB] FAIL rs_next_addr: got %h expected 104", bus_b.instr_address_out); end
      n_cmp++; if (valid_b !== 1'b1 || pcout_b !== 32'h100) begin n_fail++; $display("[TB] FAIL rs_resume: got valid %b pc %h expected 1 100", valid_b, pcout_b); end
   endtask

   task automatic test_mem_wait();
      redirect(32'h20);
      rd_ready = 1'b0;
      rd_value = 32'hDEAD_BEEF;
      step();
      n_cmp++; if (bus_b.instr_address_out !== 32'h20) begin n_fail++; $display("[TB] FAIL wait_addr1: got %h expected 20", bus_b.instr_address_out); end
      n_cmp++; if (valid_b !== 1'b0 || instr_b !== NOP || pcout_b !== 32'h0) begin n_fail++; $display("[TB] FAIL wait_bubble1: got valid %b instr %h pc %h expected 0 %h 0", valid_b, instr_b, pcout_b, NOP); end
      step();
      n_cmp++; if (bus_b.instr_address_out !== 32'h20) begin n_fail++; $display("[TB] FAIL wait_addr2: got %h expected 20", bus_b.instr_address_out); end
      n_cmp++; if (valid_b !== 1'b0 || taken_b !== 1'b0) begin n_fail++; $display("[TB] FAIL wait_bubble2: got valid %b taken %b expected 0 0", valid_b, taken_b); end
      rd_ready = 1'b1;
      rd_value = JAL_80;
      step();
      n_cmp++; if (bus_b.instr_address_out !== 32'hA0) begin n_fail++; $display("[TB] FAIL jal_addr: got %h expected A0", bus_b.instr_address_out); end
      n_cmp++; if (valid_b !== 1'b1 || taken_b !== 1'b1 || instr_b !== JAL_80 || pcout_b !== 32'h20) begin n_fail++; $display("[TB] FAIL jal_out: got valid %b taken %b instr %h pc %h expected 1 1 %h 20", valid_b, taken_b, instr_b, pcout_b, JAL_80); end
   endtask

   task automatic test_stall_flush();
      rd_value = NOP;
      stall = 1'b1; flush = 1'b1;
      step();
      n_cmp++; if (valid_b !== 1'b1 || taken_b !== 1'b1 || instr_b !== JAL_80 || pcout_b !== 32'h20) begin n_fail++; $display("[TB] FAIL stall_hold: got valid %b taken %b instr %h pc %h expected 1 1 %h 20", valid_b, taken_b, instr_b, pcout_b, JAL_80); end
      n_cmp++; if (bus_b.instr_address_out !== 32'hA4) begin n_fail++; $display("[TB] FAIL stall_pc_runs: got %h expected A4", bus_b.instr_address_out); end
      stall = 1'b0;
      step();
      n_cmp++; if (valid_b !== 1'b0 || taken_b !== 1'b0 || instr_b !== NOP || pcout_b !== 32'h0) begin n_fail++; $display("[TB] FAIL flush_bubble: got valid %b taken %b instr %h pc %h expected 0 0 %h 0", valid_b, taken_b, instr_b, pcout_b, NOP); end
      flush = 1'b0;
      step();
      n_cmp++; if (valid_b !== 1'b1 || pcout_b !== 32'hA8) begin n_fail++; $display("[TB] FAIL flush_resume: got valid %b pc %h expected 1 A8", valid_b, pcout_b); end
   endtask

   task automatic test_wraparound();
      redirect(32'hFFFF_FFFC);
      n_cmp++; if (bus_b.instr_address_out !== 32'hFFFF_FFFC) begin n_fail++; $display("[TB] FAIL wrap_start: got %h expected FFFFFFFC", bus_b.instr_address_out); end
      rd_value = NOP;
      step();
      n_cmp++; if (bus_b.instr_address_out !== 32'h0) begin n_fail++; $display("[TB] FAIL wrap_next: got %h expected 0", bus_b.instr_address_out); end
      n_cmp++; if (pcout_b !== 32'hFFFF_FFFC) begin n_fail++; $display("[TB] FAIL wrap_pc_out: got %h expected FFFFFFFC", pcout_b); end
   endtask

   task automatic test_reset_priority();
      reset      = 1'b1;
      upd_valid  = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1;
      mispredict = 1'b1; branch_pc = 32'h300;
      step();
      reset = 1'b0; upd_valid = 1'b0; mispredict = 1'b0;
      n_cmp++; if (bus_b.instr_address_out !== 32'h0) begin n_fail++; $display("[TB] FAIL rstpri_addr: got %h expected 0", bus_b.instr_address_out); end
      redirect(32'h40);
      rd_value = BEQ_M16;
      step();
      n_cmp++; if (taken_b !== 1'b0 || bus_b.instr_address_out !== 32'h44) begin n_fail++; $display("[TB] FAIL rstpri_update_lost: got taken %b addr %h expected 0 44", taken_b, bus_b.instr_address_out); end
   endtask

   // Run every scenario in order, then report
   initial begin
      n_cmp = 0; n_fail = 0;
      reset = 1'b1; pcgen_stall = 1'b0; stall = 1'b0; flush = 1'b0;
      mispredict = 1'b0; branch_pc = 32'h0;
      upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0;
      rd_value = NOP; rd_ready = 1'b1;
      test_reset();
      test_sequential();
      test_bht_training();
      test_collision();
      test_static();
      test_redirect_stall();
      test_mem_wait();
      test_stall_flush();
      test_wraparound();
      test_reset_priority();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
